// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one UART transmitter from NUM_REQ requesters,
// launching one frame at a time and supervising the transmitter busy handshake.
module uart_tx_arbiter #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int NUM_REQ          = 4,
    parameter int BUSY_TIMEOUT     = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic                                tx_enable,
    output logic [INPUT_DATA_WIDTH-1:0]         tx_data,
    input  logic                                tx_busy,
    output logic                                active,
    output logic                                done,
    output logic [$clog2(NUM_REQ)-1:0]          done_id,
    output logic                                timeout_err
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] ptr_next;
    logic             found;
    logic [CNT_W-1:0] cnt;
    logic             grant_ok;
    logic             busy_expired;

    // Rotating priority search: first set request at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        ptr_next = IDX_W'((int'(win) + 1) % NUM_REQ);
    end

    assign grant_ok     = !reset && (state == IDLE) && !tx_busy && found;
    assign busy_expired = (cnt == CNT_W'(BUSY_TIMEOUT - 1));

    // Strobes are decoded from the current state so each lands in its own cycle.
    assign gnt         = grant_ok ? (NUM_REQ'(1) << win) : '0;
    assign tx_enable   = !reset && (state == LAUNCH);
    assign done        = !reset && (state == WAIT_DONE) && !tx_busy;
    assign timeout_err = !reset && (state == WAIT_BUSY) && !tx_busy && busy_expired;
    assign active      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            tx_data <= '0;
            done_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        tx_data <= req_data[int'(win)*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
                        done_id <= win;
                        ptr     <= ptr_next;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (busy_expired) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
